// File: rtl/dma_job_scheduler_if.sv
// dma_job_scheduler_if: Avalon-MM write channel toward the DMA controller CSR slave
interface dma_job_scheduler_if;
    logic [2:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    modport master (output avm_address, avm_write, avm_writedata, input avm_waitrequest);
    modport slave (input avm_address, avm_write, avm_writedata, output avm_waitrequest);
endinterface

// File: rtl/dma_job_scheduler.sv
// dma_job_scheduler: round-robin job arbiter that programs a DMA over Avalon-MM and tracks completion
module dma_job_scheduler #(
    parameter int          ADDR_W      = 32,
    parameter int          LEN_W       = 16,
    parameter int          TIMEOUT_CYC = 1000000,
    parameter logic [31:0] CTRL_GO     = 32'h0000_008C
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [ADDR_W-1:0]     src0,
    input  logic [ADDR_W-1:0]     dst0,
    input  logic [ADDR_W-1:0]     src1,
    input  logic [ADDR_W-1:0]     dst1,
    input  logic [LEN_W-1:0]      len0,
    input  logic [LEN_W-1:0]      len1,
    output logic [1:0]            ack,
    output logic [1:0]            err,
    output logic                  busy,
    output logic                  led_done,
    output logic [15:0]           done_count,
    input  logic                  wm_done,
    dma_job_scheduler_if.master   avm
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, ARB, W_STAT, W_RADDR, W_WADDR, W_LEN, W_CTRL, WAIT_DONE, ABORT, FINISH
    } state_t;

    state_t              state, next;
    logic                g, last;
    logic [ADDR_W-1:0]   src_r, dst_r;
    logic [LEN_W-1:0]    len_r;
    logic [CW-1:0]       cnt;
    logic                wm_d;

    // requester 1 wins when alone or when both ask and requester 0 had the last grant
    wire             sel     = (req == 2'b11) ? ~last : req[1];
    wire [LEN_W-1:0] sel_len = sel ? len1 : len0;
    wire             wm_rise = wm_done & ~wm_d;
    wire             wr_done = ~avm.avm_waitrequest;
    wire             zero_job = (state == ARB) && (req != 2'b00) && (sel_len == '0);

    assign busy = state != IDLE;

    // state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // next-state: each write state advances only once the slave accepts the write
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = (req != 2'b00) ? ARB : IDLE;
            ARB:       next = (req == 2'b00 || sel_len == '0) ? IDLE : W_STAT;
            W_STAT:    next = wr_done ? W_RADDR : W_STAT;
            W_RADDR:   next = wr_done ? W_WADDR : W_RADDR;
            W_WADDR:   next = wr_done ? W_LEN : W_WADDR;
            W_LEN:     next = wr_done ? W_CTRL : W_LEN;
            W_CTRL:    next = wr_done ? WAIT_DONE : W_CTRL;
            WAIT_DONE: next = wm_rise ? FINISH : (cnt == CW'(TIMEOUT_CYC - 1)) ? ABORT : WAIT_DONE;
            ABORT:     next = wr_done ? IDLE : ABORT;
            FINISH:    next = IDLE;
            default:   next = IDLE;
        endcase
    end

    // CSR write decode: address/data depend only on state and latched job, so they hold during stalls
    always_comb begin
        avm.avm_write     = 1'b1;
        avm.avm_address   = 3'd0;
        avm.avm_writedata = 32'd0;
        case (state)
            W_STAT:  ;
            W_RADDR: begin avm.avm_address = 3'd1; avm.avm_writedata = 32'(src_r); end
            W_WADDR: begin avm.avm_address = 3'd2; avm.avm_writedata = 32'(dst_r); end
            W_LEN:   begin avm.avm_address = 3'd3; avm.avm_writedata = 32'(len_r); end
            W_CTRL:  begin avm.avm_address = 3'd6; avm.avm_writedata = CTRL_GO; end
            ABORT:   avm.avm_address = 3'd6;
            default: avm.avm_write = 1'b0;
        endcase
    end

    // job latch at arbitration, wm_done edge history and WAIT_DONE cycle counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            g     <= 1'b0;
            last  <= 1'b1;
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
            cnt   <= '0;
            wm_d  <= 1'b0;
        end else begin
            wm_d <= wm_done;
            cnt  <= (state == WAIT_DONE) ? cnt + CW'(1) : '0;
            if (state == ARB && req != 2'b00) begin
                g     <= sel;
                last  <= sel;
                src_r <= sel ? src1 : src0;
                dst_r <= sel ? dst1 : dst0;
                len_r <= sel_len;
            end
        end
    end

    // completion pulses and sticky status; ack rides with FINISH, err with the return to IDLE
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ack        <= 2'b00;
            err        <= 2'b00;
            led_done   <= 1'b0;
            done_count <= 16'd0;
        end else begin
            ack <= (next == FINISH) ? (g ? 2'b10 : 2'b01) : 2'b00;
            err <= zero_job ? (sel ? 2'b10 : 2'b01) :
                   (state == ABORT && wr_done) ? (g ? 2'b10 : 2'b01) : 2'b00;
            if (next == FINISH) begin
                led_done <= 1'b1;
                if (done_count != 16'hFFFF) done_count <= done_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dma_job_scheduler.sv
// tb_dma_job_scheduler: scoreboard bench for the DMA job scheduler
module tb_dma_job_scheduler;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [31:0] src0 = 0, dst0 = 0, src1 = 0, dst1 = 0;
    logic [15:0] len0 = 0, len1 = 0;
    logic [1:0]  ack, err;
    logic        busy, led_done;
    logic        wm_done = 1'b0;
    logic [15:0] done_count;
    int          checks = 0, errors = 0;

    typedef struct packed { logic [2:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic [1:0] ack; logic [1:0] err; logic [15:0] dc; logic led; } ev_t;
    wr_t wq[$];
    ev_t eq[$];

    dma_job_scheduler_if bus();

    dma_job_scheduler #(.TIMEOUT_CYC(50)) dut (
        .CLOCK_50(clk), .reset(reset), .req(req),
        .src0(src0), .dst0(dst0), .src1(src1), .dst1(dst1),
        .len0(len0), .len1(len1),
        .ack(ack), .err(err), .busy(busy), .led_done(led_done),
        .done_count(done_count), .wm_done(wm_done), .avm(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        wq.push_back({3'd0, 32'd0});
        wq.push_back({3'd1, s});
        wq.push_back({3'd2, d});
        wq.push_back({3'd3, l});
        wq.push_back({3'd6, 32'h8C});
    endtask

    task automatic exp_ev(input logic [1:0] a, input logic [1:0] e, input logic [15:0] dc);
        eq.push_back({a, e, dc, 1'b1});
    endtask

    // walks the job up to the W_CTRL cycle, optionally stalling W_WADDR, and checks the latency
    task automatic wait_ctrl(input int stall, input int exp_n);
        int n = 0;
        bit stalled = 0;
        do begin
            tick(1);
            n++;
            if (stall > 0 && !stalled && bus.avm_write && bus.avm_address == 3'd2) begin
                stalled = 1;
                bus.avm_waitrequest = 1'b1;
                tick(stall);
                n += stall;
                bus.avm_waitrequest = 1'b0;
            end
        end while (!(bus.avm_write && bus.avm_address == 3'd6 && bus.avm_writedata == 32'h8C) && n < 300);
        chk("ctrl_latency", n, exp_n);
    endtask

    // pulses wm_done 20 cycles after W_CTRL and expects ack in the following cycle
    task automatic finish_job(input logic [1:0] exp_ack, input logic [1:0] keep);
        tick(20);
        wm_done = 1'b1;
        tick(1);
        chk("ack_latency", ack, exp_ack);
        wm_done = 1'b0;
        req = req & keep;
    endtask

    // monitor: pops expectations whenever the DUT completes a write or pulses ack/err
    initial begin
        logic [2:0]  pa;
        logic [31:0] pd;
        bit          ps;
        wr_t         w;
        ev_t         e;
        ps = 0;
        forever begin
            @(negedge clk);
            if (ps) begin
                chk("stall_addr_hold", bus.avm_address, pa);
                chk("stall_data_hold", bus.avm_writedata, pd);
            end
            ps = bus.avm_write && bus.avm_waitrequest;
            pa = bus.avm_address;
            pd = bus.avm_writedata;
            if (bus.avm_write && !bus.avm_waitrequest) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h, required no write", bus.avm_address, bus.avm_writedata);
                end else begin
                    w = wq.pop_front();
                    chk("write_addr", bus.avm_address, w.a);
                    chk("write_data", bus.avm_writedata, w.d);
                end
            end
            if ((ack | err) != 2'b00) begin
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got ack %b err %b, required none", ack, err);
                end else begin
                    e = eq.pop_front();
                    chk("event_ack", ack, e.ack);
                    chk("event_err", err, e.err);
                    chk("event_done_count", done_count, e.dc);
                    chk("event_led", led_done, e.led);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.avm_waitrequest = 1'b0;
        tick(2);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_led", led_done, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_write", bus.avm_write, 0);
        chk("rst_addr", bus.avm_address, 0);
        chk("rst_data", bus.avm_writedata, 0);
        reset = 1'b0;
        tick(2);

        // single job on requester 0
        src0 = 32'h1000; dst0 = 32'h2000; len0 = 16'd64;
        exp_job(32'h1000, 32'h2000, 64);
        exp_ev(2'b01, 2'b00, 16'd1);
        req = 2'b01;
        wait_ctrl(0, 6);
        finish_job(2'b01, 2'b00);
        tick(2);
        chk("single_busy_idle", busy, 0);

        // zero-length job on requester 1: error without touching the DMA
        src1 = 32'h5000; dst1 = 32'h6000; len1 = 16'd0;
        exp_ev(2'b00, 2'b10, 16'd1);
        req = 2'b10;
        tick(1);
        chk("zlen_no_write_a", bus.avm_write, 0);
        tick(1);
        chk("zlen_err_latency", err, 2'b10);
        chk("zlen_no_write_b", bus.avm_write, 0);
        req = 2'b00;
        tick(2);

        // both requesters held: round-robin 0,1,0,1
        src0 = 32'h3000; dst0 = 32'h4000; len0 = 16'd8;
        len1 = 16'd16;
        exp_job(32'h3000, 32'h4000, 8);  exp_ev(2'b01, 2'b00, 16'd2);
        exp_job(32'h5000, 32'h6000, 16); exp_ev(2'b10, 2'b00, 16'd3);
        exp_job(32'h3000, 32'h4000, 8);  exp_ev(2'b01, 2'b00, 16'd4);
        exp_job(32'h5000, 32'h6000, 16); exp_ev(2'b10, 2'b00, 16'd5);
        req = 2'b11;
        wait_ctrl(0, 6); finish_job(2'b01, 2'b11);
        wait_ctrl(0, 7); finish_job(2'b10, 2'b11);
        wait_ctrl(0, 7); finish_job(2'b01, 2'b11);
        wait_ctrl(0, 7); finish_job(2'b10, 2'b00);
        tick(2);

        // three wait states on the write-address write
        src0 = 32'h1100; dst0 = 32'h2200; len0 = 16'd128;
        exp_job(32'h1100, 32'h2200, 128);
        exp_ev(2'b01, 2'b00, 16'd6);
        req = 2'b01;
        wait_ctrl(3, 9);
        finish_job(2'b01, 2'b00);
        tick(2);

        // timeout: no wm_done, abort write then err
        src1 = 32'h7000; dst1 = 32'h8000; len1 = 16'd4;
        exp_job(32'h7000, 32'h8000, 4);
        wq.push_back({3'd6, 32'd0});
        exp_ev(2'b00, 2'b10, 16'd6);
        req = 2'b10;
        wait_ctrl(0, 6);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (err == 2'b00 && n < 200);
        chk("timeout_latency", n, 52);
        chk("timeout_err", err, 2'b10);
        req = 2'b00;
        tick(2);

        // next job after the timeout runs normally
        src0 = 32'h9000; dst0 = 32'hA000; len0 = 16'd32;
        exp_job(32'h9000, 32'hA000, 32);
        exp_ev(2'b01, 2'b00, 16'd7);
        req = 2'b01;
        wait_ctrl(0, 6);
        finish_job(2'b01, 2'b00);
        tick(2);

        // reset while waiting for completion
        src0 = 32'hB000; dst0 = 32'hC000; len0 = 16'd12;
        exp_job(32'hB000, 32'hC000, 12);
        req = 2'b01;
        wait_ctrl(0, 6);
        tick(5);
        reset = 1'b1;
        req = 2'b00;
        #1;
        chk("midrst_write", bus.avm_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_led", led_done, 0);
        chk("midrst_done_count", done_count, 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        wm_done = 1'b1;
        tick(1);
        wm_done = 1'b0;
        chk("post_rst_no_ack", ack, 0);
        tick(3);
        chk("post_rst_no_ack_later", ack, 0);
        chk("write_queue_empty", wq.size(), 0);
        chk("event_queue_empty", eq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
